// File: rtl/mem_access_pkg.sv
// Shared types and constants for the 64-bit load/store unit.
// MEM_ACCESS_UNIT_READBACK_EN adds the store read-back verify states.
package mem_access_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
`ifdef MEM_ACCESS_UNIT_READBACK_EN
    ,
    ST_VERIFY,
    ST_VCHECK
`endif
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response channel of the load/store unit.
// The CPU is the master; the unit is the slave.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/mem_access_addr_check.sv
// Combinational legality test for a byte address: must be word aligned
// and must fall inside the WORDS-deep RAM.
module mem_access_addr_check
  import mem_access_pkg::*;
#(
  parameter int WORDS = 32
) (
  input  logic [63:0] addr,
  output logic        fault
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (addr & 64'(WORD_BYTES - 1)) != '0;
  assign w_out_of_range = (addr >> WORD_SHIFT) >= 64'(WORDS);
  assign fault          = w_misaligned || w_out_of_range;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request channel and a 1-cycle-latency data RAM.
// Define MEM_ACCESS_UNIT_READBACK_EN to re-read and verify every store.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORDS = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_access_unit_if.slave   bus,
  output logic [63:0]        ram_address,
  output logic               ram_read_en,
  output logic               ram_write_en,
  output logic [63:0]        ram_data_in,
  input  logic [63:0]        ram_out
);

  state_t      r_state;
  logic        r_write;
  logic [63:0] r_wdata;
  logic [63:0] r_ram_address;
  logic        r_ram_read_en;
  logic        r_ram_write_en;
  logic [63:0] r_ram_data_in;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_rdata;
  logic        r_rsp_fault;
  logic        w_fault;

  mem_access_addr_check #(.WORDS(WORDS)) u_addr_check (
    .addr  (bus.req_addr),
    .fault (w_fault)
  );

  // NOTE: gated with reset_n so ready is low during reset yet high the
  // very first cycle after release, which a registered flag cannot do.
  assign bus.req_ready = reset_n && (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;

  assign ram_address  = r_ram_address;
  assign ram_read_en  = r_ram_read_en;
  assign ram_write_en = r_ram_write_en;
  assign ram_data_in  = r_ram_data_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_write        <= 1'b0;
      r_wdata        <= '0;
      r_ram_address  <= '0;
      r_ram_read_en  <= 1'b0;
      r_ram_write_en <= 1'b0;
      r_ram_data_in  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_fault    <= 1'b0;
    end else begin
      // NOTE: RAM strobes default low each edge, so any state that sets
      // them produces a single-cycle pulse with no explicit clear.
      r_ram_read_en  <= 1'b0;
      r_ram_write_en <= 1'b0;
      r_ram_data_in  <= '0;

      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            r_write <= bus.req_write;
            r_wdata <= bus.req_wdata;
            if (w_fault) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state        <= ST_ISSUE;
              r_ram_address  <= bus.req_addr >> WORD_SHIFT;
              r_ram_read_en  <= !bus.req_write;
              r_ram_write_en <= bus.req_write;
              r_ram_data_in  <= bus.req_wdata;
            end
          end
        end

        ST_ISSUE: r_state <= ST_CAPTURE;

        ST_CAPTURE: begin
`ifdef MEM_ACCESS_UNIT_READBACK_EN
          if (r_write) begin
            r_state       <= ST_VERIFY;
            r_ram_read_en <= 1'b1;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= ram_out;
          end
`else
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= 1'b0;
          r_rsp_rdata <= r_write ? r_wdata : ram_out;
`endif
        end

`ifdef MEM_ACCESS_UNIT_READBACK_EN
        ST_VERIFY: r_state <= ST_VCHECK;

        // Read-back word is on ram_out now; a mismatch marks the store bad.
        ST_VCHECK: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= (ram_out != r_wdata);
          r_rsp_rdata <= ram_out;
        end
`endif

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WORDS, default 32, giving the number of 64-bit RAM words addressable.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, CPU load/store request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_write, input, 1, 1=store (STUR), 0=load (LDUR).
REQ-007 SHALL have port req_addr, input, 64, byte address.
REQ-008 SHALL have port req_wdata, input, 64, store data.
REQ-009 SHALL have port rsp_valid, output, 1, response present.
REQ-010 SHALL have port rsp_ready, input, 1, CPU accepts response.
REQ-011 SHALL have port rsp_rdata, output, 64, load data or write echo.
REQ-012 SHALL have port rsp_fault, output, 1, access error.
REQ-013 SHALL have ports ram_address (out, 64), ram_read_en (out, 1), ram_write_en (out, 1), ram_data_in (out, 64), ram_out (in, 64): initiator side of the data RAM port.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, CAPTURE, RESP (plus VERIFY, VCHECK per REQ-026).
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge with req_valid&&req_ready, latching write, addr, wdata.
REQ-016 SHALL flag fault when req_addr[2:0]!=0 (misaligned) or req_addr>>3 >= WORDS (out of range); faulted requests go IDLE->RESP with rsp_fault=1, rsp_rdata=0, and never assert a RAM enable.
REQ-017 SHALL, for a legal request, go IDLE->ISSUE and drive ram_address=req_addr>>3, ram_data_in=wdata, and exactly one of ram_read_en/ram_write_en high for exactly the ISSUE cycle.
REQ-018 SHALL hold both RAM enables low and ram_data_in at 0 in every state other than ISSUE and VERIFY.
REQ-019 SHALL go ISSUE->CAPTURE->RESP, latching ram_out into rsp_rdata on the CAPTURE->RESP edge (RAM delivers one cycle after the enable edge; a write echoes its data).
REQ-020 SHALL assert rsp_valid for a legal access exactly 3 edges after the accepting edge, and for a faulted access 1 edge after.
REQ-021 SHALL hold rsp_valid, rsp_rdata, rsp_fault stable in RESP until rsp_ready=1, then return to IDLE on that edge; no request is accepted on that same edge.
REQ-022 SHALL never assert ram_read_en and ram_write_en in the same cycle.

Reset
REQ-023 SHALL on reset_n=0 asynchronously enter IDLE and force req_ready=0 while reset asserted, rsp_valid=0, rsp_rdata=0, rsp_fault=0, ram_address=0, ram_read_en=0, ram_write_en=0, ram_data_in=0.
REQ-024 SHALL abandon any in-flight access on reset: an enable cleared before the RAM's sampling edge is not performed; no response is issued for it.
REQ-025 SHALL drive req_ready=1 on the first cycle after reset_n deasserts.

Configuration
REQ-026 SHALL, with MEM_ACCESS_UNIT_READBACK_EN defined, route stores CAPTURE->VERIFY (read same address, ram_read_en=1 one cycle)->VCHECK->RESP, setting rsp_fault=1 if ram_out!=wdata at VCHECK; store latency becomes 5 edges.
REQ-027 SHALL, without MEM_ACCESS_UNIT_READBACK_EN, omit VERIFY/VCHECK entirely; store responses return echoed data with rsp_fault=0 at 3-edge latency.

Structure
REQ-028 SHALL place the state enum typedef, WORD_BYTES=8 and WORD_SHIFT=3 constants in shared package mem_access_pkg.
REQ-029 SHALL implement the alignment/range test as a combinational sub-module mem_access_addr_check (inputs addr, WORDS; output fault).

Verification
REQ-030 Store addr 0x10 data 0xDEADBEEF, then load 0x10 -> ram_write_en at ISSUE with ram_address=2; load rsp_rdata=0xDEADBEEF, rsp_fault=0, 3 edges after accept.
REQ-031 Load addr 0x0C -> rsp_fault=1, rsp_rdata=0 one edge after accept; no RAM enable ever high.
REQ-032 Load addr 0x100 (word 32, WORDS=32) -> rsp_fault=1; address 0xF8 (word 31) -> legal, no fault.
REQ-033 Response held with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; IDLE on the edge rsp_ready=1.
REQ-034 reset_n pulsed low during ISSUE of a store to 0x08 -> enables drop immediately, later load of 0x08 returns its prior value, no response for the aborted store.
REQ-035 With MEM_ACCESS_UNIT_READBACK_EN, store 0x55 to 0x20 with RAM model forced to corrupt -> rsp_fault=1 at 5 edges; uncorrupted -> rsp_fault=0.
